// File: rtl/lsu_stage_pkg.sv
// ----------------------------------------------------------------------------
// lsu_stage_pkg
// Shared constants for the load/store unit stage:
//   - RV32 load/store funct3 size/sign codes
//   - lsu_state_t : FSM state encoding for lsu_stage
//   - is_misaligned() : combinational alignment check for a request
// ----------------------------------------------------------------------------
package lsu_stage_pkg;

   // Load funct3 codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store funct3 codes
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2,
      RESP  = 2'd3
   } lsu_state_t;

   // Halfwords need addr[0]=0, words need addr[1:0]=00; bytes always align.
   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
      logic mis;
      case (funct3[1:0])
         2'b01:   mis = addr_lo[0];
         2'b10:   mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_stage.sv
// ----------------------------------------------------------------------------
// lsu_stage
// Single-outstanding load/store stage between execute and writeback.
// Accepts one request in IDLE, performs a single-cycle memory access
// (LOAD or STORE), or skips it for misaligned requests, then holds the
// response in RESP until writeback consumes it.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   req_*                  execute-stage request (valid/ready handshake)
//   mem_*                  downstream byte-addressable memory interface;
//                          mem_rdata_i is combinational, already sized/extended
//   rsp_*                  writeback response (valid/ready handshake)
//   load_cnt_o/store_cnt_o completed-access counters (wrap at 2^32)
// ----------------------------------------------------------------------------
module lsu_stage
   import lsu_stage_pkg::*;
#(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_is_store_i,
   input  logic [AWIDTH-1:0] req_addr_i,
   input  logic [DWIDTH-1:0] req_wdata_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [4:0]        req_rd_i,

   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic [2:0]        mem_funct3_o,
   output logic              mem_read_en_o,
   output logic              mem_write_en_o,
   input  logic [DWIDTH-1:0] mem_rdata_i,

   output logic              rsp_valid_o,
   output logic [DWIDTH-1:0] rsp_rdata_o,
   output logic [4:0]        rsp_rd_o,
   output logic              rsp_misaligned_o,
   output logic              rsp_is_store_o,
   input  logic              rsp_ready_i,

   output logic [31:0]       load_cnt_o,
   output logic [31:0]       store_cnt_o
);

   lsu_state_t        state, state_next;

   // Request register
   logic [AWIDTH-1:0] req_addr;
   logic [DWIDTH-1:0] req_wdata;
   logic [2:0]        req_funct3;
   logic [4:0]        req_rd;
   logic              req_is_store;
   logic              req_mis;

   logic [DWIDTH-1:0] rsp_rdata;
   logic [31:0]       load_cnt;
   logic [31:0]       store_cnt;

   logic              handshake;
   logic              mis_now;

   assign handshake = req_valid_i && (state == IDLE);
   assign mis_now   = is_misaligned(req_funct3_i, req_addr_i[1:0]);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid_i) begin
               if (mis_now)             state_next = RESP;
               else if (req_is_store_i) state_next = STORE;
               else                     state_next = LOAD;
            end
         end
         LOAD:    state_next = RESP;
         STORE:   state_next = RESP;
         RESP:    if (rsp_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request capture, load data capture and access counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_addr     <= '0;
         req_wdata    <= '0;
         req_funct3   <= '0;
         req_rd       <= '0;
         req_is_store <= 1'b0;
         req_mis      <= 1'b0;
         rsp_rdata    <= '0;
         load_cnt     <= '0;
         store_cnt    <= '0;
      end else begin
         if (handshake) begin
            req_addr     <= req_addr_i;
            req_wdata    <= req_wdata_i;
            req_funct3   <= req_funct3_i;
            req_rd       <= req_rd_i;
            req_is_store <= req_is_store_i;
            req_mis      <= mis_now;
            // Stores and misaligned requests respond with zero data.
            rsp_rdata    <= '0;
         end
         // LOAD and STORE always exit after one cycle, so counting while
         // in the state is the same as counting on exit.
         if (state == LOAD) begin
            rsp_rdata <= mem_rdata_i;
            load_cnt  <= load_cnt + 32'd1;
         end
         if (state == STORE) begin
            store_cnt <= store_cnt + 32'd1;
         end
      end
   end

   assign req_ready_o      = (state == IDLE);

   assign mem_addr_o       = req_addr;
   assign mem_data_o       = req_wdata;
   assign mem_funct3_o     = req_funct3;
   assign mem_read_en_o    = (state == LOAD);
   assign mem_write_en_o   = (state == STORE);

   assign rsp_valid_o      = (state == RESP);
   assign rsp_rdata_o      = rsp_rdata;
   assign rsp_rd_o         = req_rd;
   assign rsp_misaligned_o = req_mis;
   assign rsp_is_store_o   = req_is_store;

   assign load_cnt_o       = load_cnt;
   assign store_cnt_o      = store_cnt;

endmodule

// File: tb/tb_lsu_stage.sv
// ----------------------------------------------------------------------------
// tb_lsu_stage
// Self-checking bench for lsu_stage: a table of directed load/store requests
// with hand-computed responses, plus hand-written sequences for response
// back-pressure, reset during a store, and store counter wrap.
// A 64-byte little-endian memory model sits on the mem_* interface.
// ----------------------------------------------------------------------------
module tb_lsu_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_is_store_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic [2:0]  req_funct3_i;
   logic [4:0]  req_rd_i;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [2:0]  mem_funct3_o;
   logic        mem_read_en_o;
   logic        mem_write_en_o;
   logic [31:0] mem_rdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic [4:0]  rsp_rd_o;
   logic        rsp_misaligned_o;
   logic        rsp_is_store_o;
   logic        rsp_ready_i;
   logic [31:0] load_cnt_o;
   logic [31:0] store_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_lcnt = '0;
   logic [31:0] exp_scnt = '0;

   always #5 clk = ~clk;

   lsu_stage #(.AWIDTH(32), .DWIDTH(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .req_is_store_i   (req_is_store_i),
      .req_addr_i       (req_addr_i),
      .req_wdata_i      (req_wdata_i),
      .req_funct3_i     (req_funct3_i),
      .req_rd_i         (req_rd_i),
      .mem_addr_o       (mem_addr_o),
      .mem_data_o       (mem_data_o),
      .mem_funct3_o     (mem_funct3_o),
      .mem_read_en_o    (mem_read_en_o),
      .mem_write_en_o   (mem_write_en_o),
      .mem_rdata_i      (mem_rdata_i),
      .rsp_valid_o      (rsp_valid_o),
      .rsp_rdata_o      (rsp_rdata_o),
      .rsp_rd_o         (rsp_rd_o),
      .rsp_misaligned_o (rsp_misaligned_o),
      .rsp_is_store_o   (rsp_is_store_o),
      .rsp_ready_i      (rsp_ready_i),
      .load_cnt_o       (load_cnt_o),
      .store_cnt_o      (store_cnt_o)
   );

   // ---------------- memory model ----------------
   logic [7:0] mem [0:63];
   logic [5:0] ma0, ma1, ma2, ma3;

   assign ma0 = mem_addr_o[5:0];
   assign ma1 = ma0 + 6'd1;
   assign ma2 = ma0 + 6'd2;
   assign ma3 = ma0 + 6'd3;

   always @(posedge clk) begin
      if (mem_write_en_o) begin
         case (mem_funct3_o[1:0])
            2'b00: mem[ma0] <= mem_data_o[7:0];
            2'b01: begin
               mem[ma0] <= mem_data_o[7:0];
               mem[ma1] <= mem_data_o[15:8];
            end
            default: begin
               mem[ma0] <= mem_data_o[7:0];
               mem[ma1] <= mem_data_o[15:8];
               mem[ma2] <= mem_data_o[23:16];
               mem[ma3] <= mem_data_o[31:24];
            end
         endcase
      end
   end

   always_comb begin
      mem_rdata_i = '0;
      case (mem_funct3_o)
         3'b000:  mem_rdata_i = {{24{mem[ma0][7]}}, mem[ma0]};
         3'b100:  mem_rdata_i = {24'h0, mem[ma0]};
         3'b001:  mem_rdata_i = {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
         3'b101:  mem_rdata_i = {16'h0, mem[ma1], mem[ma0]};
         3'b010:  mem_rdata_i = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
         default: mem_rdata_i = '0;
      endcase
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        is_store;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        exp_mis;
      logic [31:0] exp_rdata;
   } vec_t;

   task automatic drive_req(input vec_t v);
      req_valid_i    = 1'b1;
      req_is_store_i = v.is_store;
      req_addr_i     = v.addr;
      req_wdata_i    = v.wdata;
      req_funct3_i   = v.f3;
      req_rd_i       = v.rd;
   endtask

   // One complete transaction with rsp_ready_i held high.
   task automatic do_txn(input string name, input vec_t v);
      int n;
      int rd_p;
      int wr_p;
      bit seen;
      @(negedge clk);
      check({name, " ready"}, {31'd0, req_ready_o}, 32'd1);
      drive_req(v);
      @(posedge clk);
      n = 0; rd_p = 0; wr_p = 0; seen = 0;
      while (!seen && n < 8) begin
         @(negedge clk);
         req_valid_i = 1'b0;
         n++;
         rd_p += int'(mem_read_en_o);
         wr_p += int'(mem_write_en_o);
         if (rsp_valid_o) seen = 1;
      end
      check({name, " rsp_seen"}, {31'd0, seen}, 32'd1);
      check({name, " latency"}, n, v.exp_mis ? 32'd1 : 32'd2);
      check({name, " rdata"}, rsp_rdata_o, v.exp_rdata);
      check({name, " misaligned"}, {31'd0, rsp_misaligned_o}, {31'd0, v.exp_mis});
      check({name, " rd"}, {27'd0, rsp_rd_o}, {27'd0, v.rd});
      check({name, " is_store"}, {31'd0, rsp_is_store_o}, {31'd0, v.is_store});
      check({name, " rd_pulses"}, rd_p, (!v.exp_mis && !v.is_store) ? 32'd1 : 32'd0);
      check({name, " wr_pulses"}, wr_p, (!v.exp_mis && v.is_store) ? 32'd1 : 32'd0);
      if (!v.exp_mis) begin
         if (v.is_store) exp_scnt = exp_scnt + 32'd1;
         else            exp_lcnt = exp_lcnt + 32'd1;
      end
      @(posedge clk);
      @(negedge clk);
      check({name, " idle"}, {31'd0, req_ready_o}, 32'd1);
      check({name, " load_cnt"}, load_cnt_o, exp_lcnt);
      check({name, " store_cnt"}, store_cnt_o, exp_scnt);
   endtask

   // ---------------- test ----------------
   vec_t vecs [12];

   initial begin
      vec_t v;
      logic [31:0] h_rdata;
      logic [4:0]  h_rd;
      logic        h_mis;
      logic        h_st;
      int          pulses;
      bit          seen;
      int          n;

      //            st    addr          wdata         f3      rd     mis   rdata
      vecs[0]  = '{1'b1, 32'h0100_0010, 32'hDEAD_BEEF, 3'b010, 5'd0,  1'b0, 32'h0000_0000}; // SW
      vecs[1]  = '{1'b0, 32'h0100_0010, 32'h0,         3'b010, 5'd5,  1'b0, 32'hDEAD_BEEF}; // LW
      vecs[2]  = '{1'b1, 32'h0100_0003, 32'h1234_56A5, 3'b000, 5'd0,  1'b0, 32'h0000_0000}; // SB
      vecs[3]  = '{1'b0, 32'h0100_0003, 32'h0,         3'b000, 5'd7,  1'b0, 32'hFFFF_FFA5}; // LB
      vecs[4]  = '{1'b0, 32'h0100_0003, 32'h0,         3'b100, 5'd8,  1'b0, 32'h0000_00A5}; // LBU
      vecs[5]  = '{1'b0, 32'h0100_0002, 32'h0,         3'b010, 5'd9,  1'b1, 32'h0000_0000}; // LW mis
      vecs[6]  = '{1'b0, 32'h0100_0011, 32'h0,         3'b001, 5'd10, 1'b1, 32'h0000_0000}; // LH mis
      vecs[7]  = '{1'b0, 32'h0100_0012, 32'h0,         3'b001, 5'd11, 1'b0, 32'hFFFF_DEAD}; // LH
      vecs[8]  = '{1'b0, 32'h0100_0010, 32'h0,         3'b101, 5'd12, 1'b0, 32'h0000_BEEF}; // LHU
      vecs[9]  = '{1'b1, 32'h0100_0013, 32'h0000_CAFE, 3'b001, 5'd13, 1'b1, 32'h0000_0000}; // SH mis
      vecs[10] = '{1'b1, 32'h0100_0011, 32'h1111_1111, 3'b010, 5'd14, 1'b1, 32'h0000_0000}; // SW mis
      vecs[11] = '{1'b0, 32'h0100_0011, 32'h0,         3'b000, 5'd15, 1'b0, 32'hFFFF_FFBE}; // LB odd

      rst            = 1'b0;
      req_valid_i    = 1'b0;
      req_is_store_i = 1'b0;
      req_addr_i     = '0;
      req_wdata_i    = '0;
      req_funct3_i   = '0;
      req_rd_i       = '0;
      rsp_ready_i    = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst req_ready", {31'd0, req_ready_o}, 32'd1);
      check("rst rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      check("rst mem_en", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
      check("rst mem_addr", mem_addr_o, 32'd0);
      check("rst rsp_fields", {26'd0, rsp_rd_o, rsp_misaligned_o} | rsp_rdata_o, 32'd0);
      check("rst counters", load_cnt_o | store_cnt_o, 32'd0);
      rst = 1'b1;

      for (int unsigned i = 0; i < 12; i++) begin
         do_txn($sformatf("vec%0d", i), vecs[i]);
      end

      // Response back-pressure: hold rsp_ready_i low for 5 cycles in RESP,
      // with another request waiting that must not be accepted.
      rsp_ready_i = 1'b0;
      v = '{1'b0, 32'h0100_0010, 32'h0, 3'b010, 5'd21, 1'b0, 32'hDEAD_BEEF};
      @(negedge clk);
      drive_req(v);
      @(posedge clk);
      @(negedge clk);
      v = '{1'b1, 32'h0100_0020, 32'h5555_5555, 3'b010, 5'd22, 1'b0, 32'h0};
      drive_req(v);
      @(negedge clk);
      check("stall rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      h_rdata = rsp_rdata_o; h_rd = rsp_rd_o; h_mis = rsp_misaligned_o; h_st = rsp_is_store_o;
      check("stall rdata", h_rdata, 32'hDEAD_BEEF);
      pulses = 0;
      for (int unsigned c = 0; c < 5; c++) begin
         @(negedge clk);
         if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== h_rdata || rsp_rd_o !== h_rd ||
             rsp_misaligned_o !== h_mis || rsp_is_store_o !== h_st || req_ready_o !== 1'b0)
            pulses += 100;
         pulses += int'(mem_read_en_o) + int'(mem_write_en_o);
      end
      check("stall stable_no_access", pulses, 32'd0);
      check("stall rd", {27'd0, rsp_rd_o}, 32'd21);
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      exp_lcnt = exp_lcnt + 32'd1;
      @(posedge clk);
      @(negedge clk);
      check("stall release idle", {31'd0, req_ready_o}, 32'd1);
      check("stall load_cnt", load_cnt_o, exp_lcnt);
      check("stall store_cnt", store_cnt_o, exp_scnt);

      // Reset asserted during the STORE cycle.
      v = '{1'b1, 32'h0100_0024, 32'h7777_7777, 3'b010, 5'd23, 1'b0, 32'h0};
      @(negedge clk);
      drive_req(v);
      @(posedge clk);
      #1;
      check("midrst wr_en_before", {31'd0, mem_write_en_o}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("midrst wr_en_after", {31'd0, mem_write_en_o}, 32'd0);
      check("midrst ready", {31'd0, req_ready_o}, 32'd1);
      check("midrst counters", load_cnt_o | store_cnt_o, 32'd0);
      req_valid_i = 1'b0;
      exp_lcnt = '0;
      exp_scnt = '0;
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      for (int unsigned c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rsp_valid_o || mem_write_en_o || mem_read_en_o) seen = 1;
      end
      check("midrst no_response", {31'd0, seen}, 32'd0);

      // Store counter wrap.
      @(negedge clk);
      force dut.store_cnt = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.store_cnt;
      @(negedge clk);
      check("wrap preset", store_cnt_o, 32'hFFFF_FFFF);
      exp_scnt = 32'hFFFF_FFFF;
      v = '{1'b1, 32'h0100_0028, 32'h0BAD_F00D, 3'b010, 5'd24, 1'b0, 32'h0};
      do_txn("wrap", v);
      check("wrap store_cnt_zero", store_cnt_o, 32'd0);

      // Stored word readable back after the wrap store.
      v = '{1'b0, 32'h0100_0028, 32'h0, 3'b010, 5'd25, 1'b0, 32'h0BAD_F00D};
      do_txn("wrap readback", v);

      n = 0;
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
